// File: rtl/mac_sched_pkg.sv
// Shared widths, default constants and the requester-id type for mac_sched.
package mac_sched_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_RES_W  = 2 * DEF_DATA_W;
  localparam int unsigned NUM_REQ    = 2;

  localparam logic [DEF_RES_W-1:0] DEF_OFFSET = 16'h004E;

  // One bit is enough to name either of the two requesters.
  typedef logic req_id_t;

endpackage : mac_sched_pkg

// File: rtl/mac_pipe.sv
// Three-stage multiply-add datapath: S1 = a*b, S2 = S1 + c, S3 = S2 + OFFSET.
// Every stage carries a valid and a requester id; all stages move together on en_i.
module mac_pipe
  import mac_sched_pkg::*;
#(
  parameter int unsigned        DATA_W = DEF_DATA_W,
  parameter int unsigned        RES_W  = 2 * DATA_W,
  parameter logic [RES_W-1:0]   OFFSET = DEF_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              in_valid_i,
  input  req_id_t           in_id_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic              s1_valid_o,
  output logic              s2_valid_o,
  output logic              s3_valid_o,
  output logic [RES_W-1:0]  res_o,
  output req_id_t           res_id_o
);

  logic              s1_v_q, s2_v_q, s3_v_q;
  req_id_t           s1_id_q, s2_id_q, s3_id_q;
  logic [RES_W-1:0]  s1_prod_q, s2_sum_q, s3_res_q;
  logic [DATA_W-1:0] s1_c_q;

  logic [RES_W-1:0]  s1_prod_d, s2_sum_d, s3_res_d;

  // Stage arithmetic; c rides along in S1 so it is added one stage later.
  always_comb begin
    s1_prod_d = RES_W'(a_i) * RES_W'(b_i);
    s2_sum_d  = s1_prod_q + RES_W'(s1_c_q);
    s3_res_d  = s2_sum_q + OFFSET;
  end

  // Pipeline registers: cleared on reset, shift together when enabled, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_id_q   <= 1'b0;
      s1_prod_q <= '0;
      s1_c_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_id_q   <= 1'b0;
      s2_sum_q  <= '0;
      s3_v_q    <= 1'b0;
      s3_id_q   <= 1'b0;
      s3_res_q  <= '0;
    end else if (en_i) begin
      s1_v_q    <= in_valid_i;
      s1_id_q   <= in_id_i;
      s1_prod_q <= s1_prod_d;
      s1_c_q    <= c_i;
      s2_v_q    <= s1_v_q;
      s2_id_q   <= s1_id_q;
      s2_sum_q  <= s2_sum_d;
      s3_v_q    <= s2_v_q;
      s3_id_q   <= s2_id_q;
      s3_res_q  <= s3_res_d;
    end
  end

  assign s1_valid_o = s1_v_q;
  assign s2_valid_o = s2_v_q;
  assign s3_valid_o = s3_v_q;
  assign res_o      = s3_res_q;
  assign res_id_o   = s3_id_q;

endmodule : mac_pipe

// File: rtl/mac_sched.sv
// Two-requester arbiter in front of a three-stage a*b+c+OFFSET pipeline.
// Define MAC_SCHED_RR_EN for round-robin arbitration; otherwise requester 0
// has fixed priority.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned          DATA_W = DEF_DATA_W,
  parameter logic [2*DATA_W-1:0]  OFFSET = DEF_OFFSET
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [DATA_W-1:0]     a0,
  input  logic [DATA_W-1:0]     b0,
  input  logic [DATA_W-1:0]     c0,
  input  logic [DATA_W-1:0]     a1,
  input  logic [DATA_W-1:0]     b1,
  input  logic [DATA_W-1:0]     c1,
  output logic [2*DATA_W-1:0]   g,
  output logic                  g_valid,
  output req_id_t               g_id,
  input  logic                  g_ready,
  output logic [1:0]            inflight
);

  localparam int unsigned RES_W = 2 * DATA_W;

  logic               advance_c;
  logic [NUM_REQ-1:0] grant_c;
  logic               accept_c;
  req_id_t            acc_id_c;
  logic [DATA_W-1:0]  a_sel_c, b_sel_c, c_sel_c;
  logic               s1_v, s2_v, s3_v;

  // The whole pipeline moves unless a finished result is waiting on downstream.
  assign advance_c = !s3_v || g_ready;

`ifdef MAC_SCHED_RR_EN
  req_id_t ptr_q, ptr_d;

  // Round-robin grant: the pointer breaks ties when both requesters are valid.
  always_comb begin
    grant_c = '0;
    if (req_valid[0] && req_valid[1]) begin
      grant_c = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_c = req_valid;
    end
  end

  // After an accepted transfer, prefer the other requester next time.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_c) begin
      ptr_d = ~acc_id_c;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed-priority grant: requester 0 always wins a tie.
  always_comb begin
    grant_c = '0;
    if (req_valid[0]) begin
      grant_c = 2'b01;
    end else if (req_valid[1]) begin
      grant_c = 2'b10;
    end
  end
`endif

  // Ready is forced low while reset is asserted so nothing looks accepted.
  assign req_ready = (advance_c && reset) ? grant_c : 2'b00;
  assign accept_c  = |(req_valid & req_ready);
  assign acc_id_c  = grant_c[1];

  // Operand select follows the granted requester.
  always_comb begin
    a_sel_c = a0;
    b_sel_c = b0;
    c_sel_c = c0;
    if (grant_c[1]) begin
      a_sel_c = a1;
      b_sel_c = b1;
      c_sel_c = c1;
    end
  end

  mac_pipe #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .OFFSET (OFFSET)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .en_i       (advance_c),
    .in_valid_i (accept_c),
    .in_id_i    (acc_id_c),
    .a_i        (a_sel_c),
    .b_i        (b_sel_c),
    .c_i        (c_sel_c),
    .s1_valid_o (s1_v),
    .s2_valid_o (s2_v),
    .s3_valid_o (s3_v),
    .res_o      (g),
    .res_id_o   (g_id)
  );

  assign g_valid  = s3_v;
  assign inflight = 2'(s1_v) + 2'(s2_v) + 2'(s3_v);

endmodule : mac_sched

// File: tb/tb_mac_sched.sv
// Directed self-checking bench for mac_sched: a table of single-shot vectors
// plus hand-written reset, arbitration, stall and mid-flight reset sequences.
module tb_mac_sched;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  a0, b0, c0, a1, b1, c1;
  logic [15:0] g;
  logic        g_valid;
  logic        g_id;
  logic        g_ready;
  logic [1:0]  inflight;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] exp_g;
  } vec_t;

  vec_t vecs [7];

  mac_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .c0        (c0),
    .a1        (a1),
    .b1        (b1),
    .c1        (c1),
    .g         (g),
    .g_valid   (g_valid),
    .g_id      (g_id),
    .g_ready   (g_ready),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [7:0] a0_v, input logic [7:0] b0_v,
                       input logic [7:0] c0_v, input logic [7:0] a1_v, input logic [7:0] b1_v,
                       input logic [7:0] c1_v, input logic gr);
    req_valid = rv;
    a0 = a0_v; b0 = b0_v; c0 = c0_v;
    a1 = a1_v; b1 = b1_v; c1 = c1_v;
    g_ready = gr;
  endtask

  function automatic logic [1:0] exp_grant(input int i);
`ifdef MAC_SCHED_RR_EN
    return (i % 2 == 1) ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rv;
    logic [15:0] exp_val;

    // id, a, b, c, expected g (a*b + c + 0x4E)
    vecs[0] = '{1'b0, 8'h03, 8'h04, 8'h05, 16'h005F};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 16'hFF4E};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 16'h004E};
    vecs[3] = '{1'b1, 8'h10, 8'h10, 8'h01, 16'h014F};
    vecs[4] = '{1'b0, 8'h80, 8'h02, 8'h00, 16'h014E};
    vecs[5] = '{1'b1, 8'hFF, 8'h01, 8'hFF, 16'h024C};
    vecs[6] = '{1'b0, 8'h0A, 8'h0B, 8'h0C, 16'h00C8};

    // Reset held with random inputs: everything must read zero.
    reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_gvalid", 32'(g_valid), 32'd0);
      check("rst_g", 32'(g), 32'd0);
      check("rst_inflight", 32'(inflight), 32'd0);
    end
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    reset = 1'b1;

    // Single-shot vectors: one accept, result exactly three cycles later, once.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      rv = vecs[v].id ? 2'b10 : 2'b01;
      if (vecs[v].id)
        drive(rv, 8'($urandom), 8'($urandom), 8'($urandom), vecs[v].a, vecs[v].b, vecs[v].c, 1'b1);
      else
        drive(rv, vecs[v].a, vecs[v].b, vecs[v].c, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      #1 check("vec_ready", 32'(req_ready), 32'(rv));
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
      #1 check("vec_early1", 32'(g_valid), 32'd0);
      @(negedge clk);
      #1 check("vec_early2", 32'(g_valid), 32'd0);
      @(negedge clk);
      #1;
      check("vec_gvalid", 32'(g_valid), 32'd1);
      check("vec_g", 32'(g), 32'(vecs[v].exp_g));
      check("vec_gid", 32'(g_id), 32'(vecs[v].id));
      @(negedge clk);
      #1 check("vec_retired", 32'(g_valid), 32'd0);
    end

    // Both requesters always valid: grant pattern and full-rate result stream.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(2'b11, 8'd2, 8'd3, 8'd1, 8'd5, 8'd5, 8'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i < 6) check("arb_ready", 32'(req_ready), 32'(exp_grant(i)));
      if (i >= 3) begin
        rv      = exp_grant(i - 3);
        exp_val = rv[1] ? 16'h0067 : 16'h0055;
        check("arb_gvalid", 32'(g_valid), 32'd1);
        check("arb_gid", 32'(g_id), 32'(rv[1]));
        check("arb_g", 32'(g), 32'(exp_val));
      end
      @(negedge clk);
      if (i == 5) drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    end
    #1 check("arb_drained", 32'(g_valid), 32'd0);

    // Fill the pipe, stall four cycles, then drain in order.
    @(negedge clk);
    drive(2'b01, 8'd1, 8'd1, 8'd0, 0, 0, 0, 1'b1);
    @(negedge clk);
    a0 = 8'd2;
    @(negedge clk);
    a0 = 8'd3;
    @(negedge clk);
    a0 = 8'd4;
    g_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_gvalid", 32'(g_valid), 32'd1);
      check("stall_g", 32'(g), 32'h004F);
      check("stall_inflight", 32'(inflight), 32'd3);
    end
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("drain_gvalid", 32'(g_valid), 32'd1);
      check("drain_g", 32'(g), 32'h004F + 32'(i));
    end
    @(negedge clk);
    #1;
    check("drain_done", 32'(g_valid), 32'd0);
    check("drain_inflight", 32'(inflight), 32'd0);

    // Reset with two results in flight: they must vanish.
    @(negedge clk);
    drive(2'b01, 8'd7, 8'd1, 8'd0, 0, 0, 0, 1'b1);
    @(negedge clk);
    a0 = 8'd8;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    g_ready = 1'b0;
    #1;
    check("mid_inflight", 32'(inflight), 32'd2);
    check("mid_gvalid", 32'(g_valid), 32'd1);
    check("mid_g", 32'(g), 32'h0055);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_gvalid", 32'(g_valid), 32'd0);
    check("mid_rst_g", 32'(g), 32'd0);
    check("mid_rst_inflight", 32'(inflight), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    g_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("post_rst_gvalid", 32'(g_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mac_sched
